// File: rtl/inst_sram_rsp_pkg.sv
// Shared constants, FSM encoding and address decode for the instruction SRAM responder.
// Latency: none (types and a pure function only).
// Backpressure: n/a.
package inst_sram_rsp_pkg;

    localparam logic [31:0] ISRAM_BASE = 32'h1c00_0000;
    localparam int          ISRAM_AW   = 12;

    typedef enum logic {
        LD_S_LOAD = 1'b0,
        LD_S_RUN  = 1'b1
    } ld_state_e;

    typedef struct packed {
        logic [31:0] off;
        logic        in_range;
        logic        misalign;
    } dec_t;

    // 33-bit compare so the window size cannot overflow for large AW.
    function automatic dec_t isram_decode(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input int          aw);
        dec_t d;
        d.off      = addr - base;
        d.in_range = ({1'b0, d.off} < (33'd4 << aw));
        d.misalign = |d.off[1:0];
        return d;
    endfunction

endpackage

// File: rtl/inst_sram_rsp_if.sv
// Instruction port, boot-loader stream and status bundle between the CPU/loader and the responder.
// Latency: wires only.
// Backpressure: loader beats move only when ld_valid && ld_ready; the instruction port never stalls.
interface inst_sram_rsp_if;

    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;

    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_data;
    logic        ld_last;

    logic        ld_done;
    logic        err;
    logic [31:0] rd_cnt;

    modport master (
        output inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
        output ld_valid, ld_data, ld_last,
        input  inst_sram_rdata, ld_ready, ld_done, err, rd_cnt
    );

    modport slave (
        input  inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
        input  ld_valid, ld_data, ld_last,
        output inst_sram_rdata, ld_ready, ld_done, err, rd_cnt
    );

endinterface

// File: rtl/inst_sram_rsp_sram_sp_be.sv
// Generic single-port word RAM with per-byte write enables, read-first.
// Latency: 1 cycle from en to rdata; rdata holds while en is low.
// Backpressure: none, accepts an access every cycle.
module sram_sp_be #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [0:(1<<AW)-1];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            rdata_q <= mem[addr];
            for (int i = 0; i < 4; i++) begin
                if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/inst_sram_rsp.sv
// Instruction SRAM responder: decode, boot loader FSM, read counter and sticky error around sram_sp_be.
// Latency: read data 1 cycle after the request, back-to-back with no bubbles.
// Backpressure: ld_ready only in LOAD (first cycle after reset excluded); instruction port never stalls.
module inst_sram_rsp
    import inst_sram_rsp_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = ISRAM_BASE,
    parameter int          AW        = ISRAM_AW,
    parameter bit          LOAD_EN   = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    inst_sram_rsp_if.slave bus
);

    localparam logic [AW:0] PTR_FULL = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

    ld_state_e     state_q, state_d;
    logic [AW:0]   ptr_q, ptr_d;
    logic          err_q, err_d;
    logic [31:0]   rd_cnt_q, rd_cnt_d;
    logic          upd_q, upd_d;
    logic          zero_q, zero_d;
    logic [31:0]   hold_q, hold_d;
    logic          ld_ready_q, ld_ready_d;

    dec_t          dec;
    logic          beat;
    logic          ram_en;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;
    logic [31:0]   rdata_out;

    assign dec  = isram_decode(bus.inst_sram_addr, ADDR_BASE, AW);
    assign beat = bus.ld_valid && ld_ready_q && (state_q == LD_S_LOAD);

    // upd_q marks a request last cycle; otherwise the output replays what it showed before.
    assign rdata_out = upd_q ? (zero_q ? 32'd0 : ram_rdata) : hold_q;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        err_d     = err_q;
        rd_cnt_d  = rd_cnt_q;
        upd_d     = 1'b0;
        zero_d    = 1'b0;
        hold_d    = rdata_out;
        ram_en    = 1'b0;
        ram_we    = 4'h0;
        ram_addr  = dec.off[AW+1:2];
        ram_wdata = bus.inst_sram_wdata;

        if (bus.inst_sram_en) begin
            upd_d = 1'b1;
            if (dec.misalign) err_d = 1'b1;
            if (state_q == LD_S_LOAD) begin
                zero_d = 1'b1;
            end else begin
                zero_d = !dec.in_range;
                if (!dec.in_range) begin
                    err_d = 1'b1;
                end else begin
                    ram_en = 1'b1;
                    ram_we = bus.inst_sram_we;
                end
                if (bus.inst_sram_we == 4'h0 && rd_cnt_q != 32'hffff_ffff) begin
                    rd_cnt_d = rd_cnt_q + 32'd1;
                end
            end
        end

        // Loader owns the RAM port in LOAD; instruction requests there never touch it.
        if (beat) begin
            if (ptr_q == PTR_FULL) begin
                err_d = 1'b1;
            end else begin
                ram_en    = 1'b1;
                ram_we    = 4'hf;
                ram_addr  = ptr_q[AW-1:0];
                ram_wdata = bus.ld_data;
                ptr_d     = ptr_q + PTR_ONE;
            end
            if (bus.ld_last) state_d = LD_S_RUN;
        end

        ld_ready_d = (state_d == LD_S_LOAD);

        if (reset) ram_en = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= LOAD_EN ? LD_S_LOAD : LD_S_RUN;
            ptr_q      <= '0;
            err_q      <= 1'b0;
            rd_cnt_q   <= 32'd0;
            upd_q      <= 1'b0;
            zero_q     <= 1'b0;
            hold_q     <= 32'd0;
            ld_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            err_q      <= err_d;
            rd_cnt_q   <= rd_cnt_d;
            upd_q      <= upd_d;
            zero_q     <= zero_d;
            hold_q     <= hold_d;
            ld_ready_q <= ld_ready_d;
        end
    end

    sram_sp_be #(.AW(AW)) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign bus.inst_sram_rdata = rdata_out;
    assign bus.ld_ready        = ld_ready_q;
    assign bus.ld_done         = (state_q == LD_S_RUN);
    assign bus.err             = err_q;
    assign bus.rd_cnt          = rd_cnt_q;

endmodule

// File: tb/tb_inst_sram_rsp.sv
// Bench for inst_sram_rsp: loader-enabled instance driven through a scoreboard, plus a LOAD_EN=0 instance.
module tb_inst_sram_rsp;

    logic clk = 1'b0;
    logic rst1 = 1'b1;
    logic rst2 = 1'b1;
    always #5 clk = ~clk;

    inst_sram_rsp_if m1();
    inst_sram_rsp_if m2();

    inst_sram_rsp #(.ADDR_BASE(32'h1c00_0000), .AW(12), .LOAD_EN(1'b1)) u_dut (
        .clk(clk), .reset(rst1), .bus(m1)
    );
    inst_sram_rsp #(.ADDR_BASE(32'h1c00_0000), .AW(12), .LOAD_EN(1'b0)) u_dut_nl (
        .clk(clk), .reset(rst2), .bus(m2)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] mem_m [4096];
    int unsigned ptr_m  = 0;
    logic        err_m  = 1'b0;
    logic [31:0] cnt_m  = 32'd0;
    bit          run_m  = 1'b0;
    logic [31:0] last_m = 32'd0;
    logic [31:0] exp_q [$];

    task automatic idle_inputs();
        m1.inst_sram_en = 1'b0; m1.inst_sram_we = 4'h0; m1.inst_sram_addr = 32'd0; m1.inst_sram_wdata = 32'd0;
        m1.ld_valid = 1'b0; m1.ld_data = 32'd0; m1.ld_last = 1'b0;
        m2.inst_sram_en = 1'b0; m2.inst_sram_we = 4'h0; m2.inst_sram_addr = 32'd0; m2.inst_sram_wdata = 32'd0;
        m2.ld_valid = 1'b0; m2.ld_data = 32'd0; m2.ld_last = 1'b0;
    endtask

    task automatic do_reset1();
        @(negedge clk);
        rst1 = 1'b1;
        m1.inst_sram_en = 1'b0; m1.ld_valid = 1'b0; m1.ld_last = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst1 = 1'b0;
        ptr_m = 0; err_m = 1'b0; cnt_m = 32'd0; run_m = 1'b0; last_m = 32'd0;
        exp_q.delete();
    endtask

    // One instruction-port request on m1; its expected rdata is queued and checked a cycle later.
    task automatic req(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] off;
        logic [31:0] expv;
        logic [31:0] got;
        logic [31:0] e;
        logic        inr;
        off  = addr - 32'h1c00_0000;
        inr  = (off < 32'h0000_4000);
        expv = 32'd0;
        if (run_m) begin
            if (inr) expv = mem_m[off[13:2]];
            else     err_m = 1'b1;
            if (we == 4'h0) begin
                if (cnt_m != 32'hffff_ffff) cnt_m = cnt_m + 32'd1;
            end else if (inr) begin
                for (int i = 0; i < 4; i++)
                    if (we[i]) mem_m[off[13:2]][8*i +: 8] = wd[8*i +: 8];
            end
        end
        if (off[1:0] != 2'b00) err_m = 1'b1;
        exp_q.push_back(expv);
        m1.inst_sram_en = 1'b1; m1.inst_sram_we = we; m1.inst_sram_addr = addr; m1.inst_sram_wdata = wd;
        @(negedge clk);
        m1.inst_sram_en = 1'b0;
        got = m1.inst_sram_rdata;
        e = exp_q.pop_front();
        last_m = e;
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL rdata addr=%h we=%b: got %h want %h", addr, we, got, e);
        end
        checks++;
        if (m1.err !== err_m || m1.rd_cnt !== cnt_m) begin
            errors++;
            $display("FAIL status addr=%h: err=%b rd_cnt=%0d want err=%b rd_cnt=%0d", addr, m1.err, m1.rd_cnt, err_m, cnt_m);
        end
    endtask

    // Offers one loader beat on m1 for up to 20 cycles; updates the model if it was taken.
    task automatic send_beat(input logic [31:0] d, input bit last, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        m1.ld_valid = 1'b1; m1.ld_data = d; m1.ld_last = last;
        while (n < 20 && !ok) begin
            ok = (m1.ld_ready === 1'b1);
            @(negedge clk);
            n++;
        end
        m1.ld_valid = 1'b0; m1.ld_last = 1'b0;
        if (ok) begin
            if (ptr_m < 4096) begin
                mem_m[ptr_m] = d;
                ptr_m++;
            end else begin
                err_m = 1'b1;
            end
            if (last) run_m = 1'b1;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst1 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (m1.inst_sram_rdata !== 32'd0 || m1.ld_ready !== 1'b0 || m1.ld_done !== 1'b0 ||
            m1.err !== 1'b0 || m1.rd_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_values: rdata=%h ld_ready=%b ld_done=%b err=%b rd_cnt=%0d want all 0",
                     m1.inst_sram_rdata, m1.ld_ready, m1.ld_done, m1.err, m1.rd_cnt);
        end
        rst1 = 1'b0;
        ptr_m = 0; err_m = 1'b0; cnt_m = 32'd0; run_m = 1'b0;
        @(negedge clk);
        checks++;
        if (m1.ld_ready !== 1'b1 || m1.ld_done !== 1'b0) begin
            errors++;
            $display("FAIL load_entry: ld_ready=%b ld_done=%b want 1 0", m1.ld_ready, m1.ld_done);
        end
    endtask

    task automatic test_load();
        logic [31:0] words [3];
        bit ok;
        words = '{32'h0280_0401, 32'h0280_0802, 32'h0280_0c03};
        req(4'h0, 32'h1c00_0000, 32'd0);
        for (int i = 0; i < 3; i++) begin
            send_beat(words[i], (i == 2), ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL beat%0d_accept: got not accepted want accepted", i);
            end
        end
        checks++;
        if (m1.ld_done !== 1'b1 || m1.ld_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_done: ld_done=%b ld_ready=%b want 1 0", m1.ld_done, m1.ld_ready);
        end
        req(4'h0, 32'h1c00_0000, 32'd0);
        req(4'h0, 32'h1c00_0004, 32'd0);
        req(4'h0, 32'h1c00_0008, 32'd0);
        checks++;
        if (m1.rd_cnt !== 32'd3) begin
            errors++;
            $display("FAIL rd_cnt_after_load: got %0d want 3", m1.rd_cnt);
        end
    endtask

    task automatic test_back_to_back();
        req(4'h0, 32'h1c00_0008, 32'd0);
        req(4'h0, 32'h1c00_0000, 32'd0);
        req(4'h0, 32'h1c00_0004, 32'd0);
    endtask

    task automatic test_write();
        req(4'b0011, 32'h1c00_0000, 32'hdead_beef);
        req(4'h0, 32'h1c00_0000, 32'd0);
        checks++;
        if (m1.inst_sram_rdata !== 32'h0280_beef) begin
            errors++;
            $display("FAIL byte_merge: got %h want %h", m1.inst_sram_rdata, 32'h0280_beef);
        end
        @(negedge clk);
        checks++;
        if (m1.inst_sram_rdata !== last_m) begin
            errors++;
            $display("FAIL rdata_hold: got %h want %h", m1.inst_sram_rdata, last_m);
        end
    endtask

    task automatic test_out_of_range();
        checks++;
        if (m1.err !== 1'b0) begin
            errors++;
            $display("FAIL err_before_oob: got %b want 0", m1.err);
        end
        req(4'h0, 32'h1bff_fffc, 32'd0);
        req(4'h0, 32'h1c00_4000, 32'd0);
        req(4'hf, 32'h1c00_4000, 32'h5555_aaaa);
        req(4'h0, 32'h1c00_0000, 32'd0);
        req(4'h0, 32'h1c00_0008, 32'd0);
    endtask

    task automatic test_overflow();
        bit ok;
        int acc;
        do_reset1();
        acc = 0;
        for (int i = 0; i < 4096; i++) begin
            send_beat(32'h1000_0000 + i, 1'b0, ok);
            if (ok) acc++;
        end
        checks++;
        if (acc != 4096 || m1.err !== 1'b0) begin
            errors++;
            $display("FAIL fill_4096: accepted=%0d err=%b want 4096 0", acc, m1.err);
        end
        send_beat(32'hffff_0000, 1'b0, ok);
        checks++;
        if (!ok || m1.err !== 1'b1 || m1.ld_done !== 1'b0 || m1.ld_ready !== 1'b1) begin
            errors++;
            $display("FAIL overflow_beat: accepted=%b err=%b ld_done=%b ld_ready=%b want 1 1 0 1",
                     ok, m1.err, m1.ld_done, m1.ld_ready);
        end
        do_reset1();
        checks++;
        if (m1.err !== 1'b0 || m1.ld_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_after_overflow: err=%b ld_done=%b want 0 0", m1.err, m1.ld_done);
        end
        send_beat(32'h1234_5678, 1'b1, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL reload_accept: got not accepted want accepted");
        end
        req(4'h0, 32'h1c00_0000, 32'd0);
        req(4'h0, 32'h1c00_0004, 32'd0);
    endtask

    task automatic test_no_load();
        rst2 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (m2.ld_done !== 1'b1 || m2.ld_ready !== 1'b0 || m2.inst_sram_rdata !== 32'd0) begin
            errors++;
            $display("FAIL nl_reset: ld_done=%b ld_ready=%b rdata=%h want 1 0 0",
                     m2.ld_done, m2.ld_ready, m2.inst_sram_rdata);
        end
        rst2 = 1'b0;
        m2.inst_sram_en = 1'b1; m2.inst_sram_we = 4'hf;
        m2.inst_sram_addr = 32'h1c00_0000; m2.inst_sram_wdata = 32'hcafe_f00d;
        @(negedge clk);
        m2.inst_sram_addr = 32'h1c00_0004; m2.inst_sram_wdata = 32'h0bad_c0de;
        @(negedge clk);
        m2.inst_sram_en = 1'b0; m2.inst_sram_we = 4'h0;
        rst2 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst2 = 1'b0;
        m2.inst_sram_en = 1'b1; m2.inst_sram_addr = 32'h1c00_0000;
        checks++;
        if (m2.ld_done !== 1'b1) begin
            errors++;
            $display("FAIL nl_first_cycle: ld_done=%b want 1", m2.ld_done);
        end
        @(negedge clk);
        m2.inst_sram_addr = 32'h1c00_0006;
        checks++;
        if (m2.inst_sram_rdata !== 32'hcafe_f00d || m2.rd_cnt !== 32'd1 || m2.err !== 1'b0) begin
            errors++;
            $display("FAIL nl_preload_read: rdata=%h rd_cnt=%0d err=%b want cafef00d 1 0",
                     m2.inst_sram_rdata, m2.rd_cnt, m2.err);
        end
        @(negedge clk);
        m2.inst_sram_en = 1'b0;
        m2.ld_valid = 1'b1; m2.ld_data = 32'd0; m2.ld_last = 1'b1;
        checks++;
        if (m2.inst_sram_rdata !== 32'h0bad_c0de || m2.err !== 1'b1) begin
            errors++;
            $display("FAIL nl_misalign: rdata=%h err=%b want 0badc0de 1", m2.inst_sram_rdata, m2.err);
        end
        @(negedge clk);
        checks++;
        if (m2.ld_ready !== 1'b0) begin
            errors++;
            $display("FAIL nl_ld_ready: got %b want 0", m2.ld_ready);
        end
        m2.ld_valid = 1'b0; m2.ld_last = 1'b0;
        m2.inst_sram_en = 1'b1; m2.inst_sram_addr = 32'h1c00_0000;
        @(negedge clk);
        m2.inst_sram_en = 1'b0;
        checks++;
        if (m2.inst_sram_rdata !== 32'hcafe_f00d || m2.rd_cnt !== 32'd3) begin
            errors++;
            $display("FAIL nl_loader_ignored: rdata=%h rd_cnt=%0d want cafef00d 3",
                     m2.inst_sram_rdata, m2.rd_cnt);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_load();
        test_back_to_back();
        test_write();
        test_out_of_range();
        test_overflow();
        test_no_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t want finished", $time);
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
